// File: rtl/sized_data_memory.sv
// Byte-addressed little-endian data memory with sized, optionally sign-extended
// accesses, a valid/ready request port and two-beat handling of word-crossing accesses.
module sized_data_memory #(
    parameter int DATA_WIDTH  = 64,
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_WIDTH  = 64
) (
    input  logic                  Clock,
    input  logic                  ResetL,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [1:0]            ReqSize,
    input  logic                  ReqSigned,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  RespValid,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Fault
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CAP   = DEPTH_WORDS * BYTES;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CAP_W = OFF_W + IDX_W;
    localparam int SUM_W = CAP_W + 5;
    localparam logic [4:0]       BYTES_N = 5'(BYTES);
    localparam logic [SUM_W-1:0] CAP_S   = SUM_W'(CAP);

    typedef enum logic {ST_IDLE, ST_SPLIT} state_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    state_e                state_q, state_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [OFF_W-1:0]      off_q, off_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic                  write_q, write_d;
    logic [IDX_W-1:0]      idx2_q, idx2_d;
    logic [DATA_WIDTH-1:0] hi_data_q, hi_data_d;
    logic [BYTES-1:0]      hi_mask_q, hi_mask_d;

    logic [OFF_W-1:0]        req_off;
    logic [IDX_W-1:0]        req_idx;
    logic [4:0]              req_n, req_span;
    logic [SUM_W-1:0]        req_end;
    logic                    req_fault, req_split, accept, in_split;
    logic [2*BYTES-1:0]      req_mask;
    logic [2*DATA_WIDTH-1:0] req_wide;
    logic [IDX_W-1:0]        rd_idx, wr_idx;
    logic [DATA_WIDTH-1:0]   rd_word, wr_data, asm_lo, asm_hi, ld_raw, ld_value;
    logic [OFF_W-1:0]        asm_off;
    logic [BYTES-1:0]        wr_mask;
    logic                    wr_en;

    function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [DATA_WIDTH-1:0] raw,
                                                          input logic [1:0] size,
                                                          input logic sgn);
        logic [DATA_WIDTH-1:0] res;
        logic                  msb;
        int                    nbits;
        res   = raw;
        nbits = 8 << size;
        case (size)
            2'd0:    msb = raw[7];
            2'd1:    msb = raw[15];
            2'd2:    msb = raw[31];
            default: msb = raw[DATA_WIDTH-1];
        endcase
        if (nbits < DATA_WIDTH) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (i >= nbits) res[i] = sgn & msb;
            end
        end
        return res;
    endfunction

    assign in_split = (state_q == ST_SPLIT);
    assign ReqReady = (state_q == ST_IDLE);
    assign accept   = ReqValid && ReqReady;

    // Range check is done on the unwrapped byte address; any bit above the capacity faults.
    always_comb begin
        req_off   = Address[OFF_W-1:0];
        req_idx   = Address[CAP_W-1:OFF_W];
        req_n     = 5'(1 << ReqSize);
        req_span  = 5'(req_off) + req_n;
        req_end   = SUM_W'(Address[CAP_W-1:0]) + SUM_W'(req_n);
        req_fault = (req_n > BYTES_N) || ((Address >> CAP_W) != '0) || (req_end > CAP_S);
        req_split = (req_span > BYTES_N);
        req_wide  = {{DATA_WIDTH{1'b0}}, WriteData} << {req_off, 3'b000};
        for (int b = 0; b < 2 * BYTES; b++) begin
            req_mask[b] = (5'(b) >= 5'(req_off)) && (5'(b) < req_span);
        end
    end

    always_comb begin
        rd_idx   = in_split ? idx2_q : req_idx;
        rd_word  = mem[rd_idx];
        asm_lo   = in_split ? hold_q : rd_word;
        asm_hi   = in_split ? rd_word : '0;
        asm_off  = in_split ? off_q : req_off;
        ld_raw   = DATA_WIDTH'({asm_hi, asm_lo} >> {asm_off, 3'b000});
        ld_value = extend_load(ld_raw, in_split ? size_q : ReqSize,
                               in_split ? signed_q : ReqSigned);
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = req_idx;
        wr_data = req_wide[DATA_WIDTH-1:0];
        wr_mask = req_mask[BYTES-1:0];
        if (in_split) begin
            wr_en   = write_q;
            wr_idx  = idx2_q;
            wr_data = hi_data_q;
            wr_mask = hi_mask_q;
        end else if (accept && ReqWrite && !req_fault) begin
            wr_en = 1'b1;
        end
    end

    // No reset on the array; writes are suppressed while reset is asserted.
    always_ff @(posedge Clock) begin
        if (ResetL && wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_mask[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        fault_d      = 1'b0;
        read_data_d  = '0;
        hold_d       = hold_q;
        off_d        = off_q;
        size_d       = size_q;
        signed_d     = signed_q;
        write_d      = write_q;
        idx2_d       = idx2_q;
        hi_data_d    = hi_data_q;
        hi_mask_d    = hi_mask_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_fault) begin
                        resp_valid_d = 1'b1;
                        fault_d      = 1'b1;
                    end else if (req_split) begin
                        state_d   = ST_SPLIT;
                        hold_d    = rd_word;
                        off_d     = req_off;
                        size_d    = ReqSize;
                        signed_d  = ReqSigned;
                        write_d   = ReqWrite;
                        idx2_d    = req_idx + IDX_W'(1);
                        hi_data_d = req_wide[2*DATA_WIDTH-1:DATA_WIDTH];
                        hi_mask_d = req_mask[2*BYTES-1:BYTES];
                    end else begin
                        resp_valid_d = 1'b1;
                        read_data_d  = ReqWrite ? '0 : ld_value;
                    end
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b1;
                read_data_d  = write_q ? '0 : ld_value;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!ResetL) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            read_data_q  <= '0;
            hold_q       <= '0;
            off_q        <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            write_q      <= 1'b0;
            idx2_q       <= '0;
            hi_data_q    <= '0;
            hi_mask_q    <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            fault_q      <= fault_d;
            read_data_q  <= read_data_d;
            hold_q       <= hold_d;
            off_q        <= off_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            write_q      <= write_d;
            idx2_q       <= idx2_d;
            hi_data_q    <= hi_data_d;
            hi_mask_q    <= hi_mask_d;
        end
    end

    assign RespValid = resp_valid_q;
    assign ReadData  = read_data_q;
    assign Fault     = fault_q;
endmodule

// File: tb/tb_sized_data_memory.sv
// Directed bench for sized_data_memory: a 64-bit instance for the main scenarios
// and a 32-bit instance for the oversize fault and a narrow split access.
module tb_sized_data_memory;
    logic        clk = 1'b0;
    logic        rst_l;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [63:0] address, write_data, read_data;
    logic        resp_valid, fault;

    logic        s_req_valid, s_req_ready, s_req_write, s_req_signed;
    logic [1:0]  s_req_size;
    logic [63:0] s_address;
    logic [31:0] s_write_data, s_read_data;
    logic        s_resp_valid, s_fault;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sized_data_memory #(.DATA_WIDTH(64), .DEPTH_WORDS(64), .ADDR_WIDTH(64)) u_dut (
        .Clock(clk), .ResetL(rst_l), .ReqValid(req_valid), .ReqReady(req_ready),
        .ReqWrite(req_write), .ReqSize(req_size), .ReqSigned(req_signed),
        .Address(address), .WriteData(write_data), .RespValid(resp_valid),
        .ReadData(read_data), .Fault(fault));

    sized_data_memory #(.DATA_WIDTH(32), .DEPTH_WORDS(64), .ADDR_WIDTH(64)) u_dut32 (
        .Clock(clk), .ResetL(rst_l), .ReqValid(s_req_valid), .ReqReady(s_req_ready),
        .ReqWrite(s_req_write), .ReqSize(s_req_size), .ReqSigned(s_req_signed),
        .Address(s_address), .WriteData(s_write_data), .RespValid(s_resp_valid),
        .ReadData(s_read_data), .Fault(s_fault));

    task automatic drive(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [63:0] addr, input logic [63:0] data);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        address    = addr;
        write_data = data;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] sz, input logic sg, input logic [63:0] addr,
                        output logic [63:0] data, output logic flt, output int lat);
        @(negedge clk);
        drive(1'b0, sz, sg, addr, 64'h0);
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 4) begin
            tick();
            lat++;
        end
        data = resp_valid ? read_data : 64'hx;
        flt  = resp_valid ? fault : 1'bx;
    endtask

    task automatic clear_mem;
        @(negedge clk);
        for (int w = 0; w < 64; w++) begin
            drive(1'b1, 2'd3, 1'b0, 64'(w * 8), 64'h0);
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [63:0] d;
        logic        f;
        int          lat;
        @(negedge clk);
        drive(1'b1, 2'd3, 1'b0, 64'h10, 64'h0123456789ABCDEF);
        tick();
        drive(1'b0, 2'd3, 1'b0, 64'h10, 64'h0);
        tick();
        rst_l = 1'b0;
        drive(1'b1, 2'd3, 1'b0, 64'h10, 64'hDEADBEEF0BADF00D);
        tick();
        tick();
        if (req_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", req_ready); else n_pass++;
        n_total++;
        if (resp_valid !== 1'b0) $display("FAIL rst_resp got %b exp 0", resp_valid); else n_pass++;
        n_total++;
        if (fault !== 1'b0) $display("FAIL rst_fault got %b exp 0", fault); else n_pass++;
        n_total++;
        if (read_data !== 64'h0) $display("FAIL rst_rdata got %h exp 0", read_data); else n_pass++;
        n_total++;
        @(negedge clk);
        req_valid = 1'b0;
        rst_l = 1'b1;
        load(2'd3, 1'b0, 64'h10, d, f, lat);
        if (d !== 64'h0123456789ABCDEF) $display("FAIL rst_nowrite got %h exp 0123456789abcdef", d); else n_pass++;
        n_total++;
    endtask

    task automatic test_aligned;
        clear_mem();
        @(negedge clk);
        drive(1'b1, 2'd3, 1'b0, 64'h8, 64'h1122334455667788);
        tick();
        if (resp_valid !== 1'b1 || fault !== 1'b0)
            $display("FAIL st_resp got v=%b f=%b exp v=1 f=0", resp_valid, fault);
        else n_pass++;
        n_total++;
        drive(1'b0, 2'd3, 1'b0, 64'h8, 64'h0);
        tick();
        req_valid = 1'b0;
        if (resp_valid !== 1'b1 || fault !== 1'b0)
            $display("FAIL ld_resp got v=%b f=%b exp v=1 f=0", resp_valid, fault);
        else n_pass++;
        n_total++;
        if (read_data !== 64'h1122334455667788)
            $display("FAIL ld_b2b got %h exp 1122334455667788", read_data);
        else n_pass++;
        n_total++;
        tick();
        if (resp_valid !== 1'b0) $display("FAIL resp_drop got %b exp 0", resp_valid); else n_pass++;
        n_total++;
    endtask

    task automatic test_subword;
        logic [63:0] d;
        logic        f;
        int          lat;
        @(negedge clk);
        drive(1'b1, 2'd0, 1'b0, 64'hB, 64'hF0);
        tick();
        req_valid = 1'b0;
        if (resp_valid !== 1'b1 || read_data !== 64'h0)
            $display("FAIL stb_resp got v=%b d=%h exp v=1 d=0", resp_valid, read_data);
        else n_pass++;
        n_total++;
        load(2'd0, 1'b1, 64'hB, d, f, lat);
        if (d !== 64'hFFFFFFFFFFFFFFF0) $display("FAIL ldb_s got %h exp fffffffffffffff0", d); else n_pass++;
        n_total++;
        load(2'd0, 1'b0, 64'hB, d, f, lat);
        if (d !== 64'hF0) $display("FAIL ldb_u got %h exp f0", d); else n_pass++;
        n_total++;
        load(2'd3, 1'b0, 64'h8, d, f, lat);
        if (d !== 64'h11223344F0667788) $display("FAIL ldd_merge got %h exp 11223344f0667788", d); else n_pass++;
        n_total++;
        load(2'd1, 1'b1, 64'hA, d, f, lat);
        if (d !== 64'hFFFFFFFFFFFFF066) $display("FAIL ldh_s got %h exp fffffffffffff066", d); else n_pass++;
        n_total++;
        load(2'd2, 1'b1, 64'h8, d, f, lat);
        if (d !== 64'hFFFFFFFFF0667788) $display("FAIL ldw_s got %h exp fffffffff0667788", d); else n_pass++;
        n_total++;
        load(2'd3, 1'b1, 64'h8, d, f, lat);
        if (d !== 64'h11223344F0667788) $display("FAIL ldd_signed got %h exp 11223344f0667788", d); else n_pass++;
        n_total++;
    endtask

    task automatic test_split;
        logic [63:0] d;
        logic        f;
        int          lat;
        clear_mem();
        @(negedge clk);
        drive(1'b1, 2'd3, 1'b0, 64'h33, 64'hAAAABBBBCCCCDDDD);
        tick();
        req_valid = 1'b0;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0)
            $display("FAIL split_beat1 got rdy=%b v=%b exp rdy=0 v=0", req_ready, resp_valid);
        else n_pass++;
        n_total++;
        tick();
        if (req_ready !== 1'b1 || resp_valid !== 1'b1 || fault !== 1'b0)
            $display("FAIL split_resp got rdy=%b v=%b f=%b exp 1 1 0", req_ready, resp_valid, fault);
        else n_pass++;
        n_total++;
        drive(1'b0, 2'd3, 1'b0, 64'h38, 64'h0);
        tick();
        req_valid = 1'b0;
        if (resp_valid !== 1'b1 || read_data !== 64'h0000000000AAAABB)
            $display("FAIL split_b2b got v=%b d=%h exp v=1 d=0000000000aaaabb", resp_valid, read_data);
        else n_pass++;
        n_total++;
        load(2'd3, 1'b0, 64'h33, d, f, lat);
        if (d !== 64'hAAAABBBBCCCCDDDD) $display("FAIL ld_split got %h exp aaaabbbbccccdddd", d); else n_pass++;
        n_total++;
        if (lat !== 2) $display("FAIL ld_split_lat got %0d exp 2", lat); else n_pass++;
        n_total++;
        load(2'd3, 1'b0, 64'h30, d, f, lat);
        if (d !== 64'hBBCCCCDDDD000000) $display("FAIL ld_w6 got %h exp bbccccdddd000000", d); else n_pass++;
        n_total++;
        if (lat !== 1) $display("FAIL ld_w6_lat got %0d exp 1", lat); else n_pass++;
        n_total++;
    endtask

    task automatic test_fault;
        logic [63:0] d;
        logic        f;
        int          lat;
        clear_mem();
        @(negedge clk);
        drive(1'b1, 2'd3, 1'b0, 64'h1FC, 64'hFFFFFFFFFFFFFFFF);
        tick();
        req_valid = 1'b0;
        if (resp_valid !== 1'b1 || fault !== 1'b1 || read_data !== 64'h0 || req_ready !== 1'b1)
            $display("FAIL flt_st got v=%b f=%b d=%h rdy=%b exp 1 1 0 1", resp_valid, fault, read_data, req_ready);
        else n_pass++;
        n_total++;
        load(2'd3, 1'b0, 64'h1F8, d, f, lat);
        if (d !== 64'h0 || f !== 1'b0) $display("FAIL flt_untouched got d=%h f=%b exp d=0 f=0", d, f); else n_pass++;
        n_total++;
        load(2'd0, 1'b0, 64'h200, d, f, lat);
        if (f !== 1'b1 || d !== 64'h0) $display("FAIL flt_cap got f=%b d=%h exp f=1 d=0", f, d); else n_pass++;
        n_total++;
        load(2'd0, 1'b0, 64'h8000000000000008, d, f, lat);
        if (f !== 1'b1) $display("FAIL flt_hibit got %b exp 1", f); else n_pass++;
        n_total++;
    endtask

    task automatic test_narrow;
        @(negedge clk);
        s_req_valid = 1'b1; s_req_write = 1'b1; s_req_size = 2'd3; s_req_signed = 1'b0;
        s_address = 64'h0; s_write_data = 32'h12345678;
        tick();
        s_req_valid = 1'b0;
        if (s_resp_valid !== 1'b1 || s_fault !== 1'b1)
            $display("FAIL n32_size3 got v=%b f=%b exp v=1 f=1", s_resp_valid, s_fault);
        else n_pass++;
        n_total++;
        @(negedge clk);
        s_req_valid = 1'b1; s_req_write = 1'b1; s_req_size = 2'd2;
        s_address = 64'h2; s_write_data = 32'hDEADBEEF;
        tick();
        s_req_valid = 1'b0;
        tick();
        if (s_resp_valid !== 1'b1 || s_fault !== 1'b0)
            $display("FAIL n32_split_st got v=%b f=%b exp v=1 f=0", s_resp_valid, s_fault);
        else n_pass++;
        n_total++;
        s_req_valid = 1'b1; s_req_write = 1'b0; s_req_size = 2'd2;
        tick();
        s_req_valid = 1'b0;
        tick();
        if (s_resp_valid !== 1'b1 || s_read_data !== 32'hDEADBEEF)
            $display("FAIL n32_split_ld got v=%b d=%h exp v=1 d=deadbeef", s_resp_valid, s_read_data);
        else n_pass++;
        n_total++;
        @(negedge clk);
        s_req_valid = 1'b1; s_req_size = 2'd1; s_req_signed = 1'b1; s_address = 64'h4;
        tick();
        s_req_valid = 1'b0;
        if (s_read_data !== 32'hFFFFDEAD) $display("FAIL n32_ldh_s got %h exp ffffdead", s_read_data); else n_pass++;
        n_total++;
    endtask

    task automatic test_reset_split;
        logic [63:0] d;
        logic        f;
        int          lat;
        clear_mem();
        @(negedge clk);
        drive(1'b1, 2'd3, 1'b0, 64'h3C, 64'h0102030405060708);
        tick();
        req_valid = 1'b0;
        rst_l = 1'b0;
        tick();
        if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL rsplit_edge got v=%b rdy=%b exp v=0 rdy=1", resp_valid, req_ready);
        else n_pass++;
        n_total++;
        @(negedge clk);
        rst_l = 1'b1;
        tick();
        if (resp_valid !== 1'b0) $display("FAIL rsplit_noresp got %b exp 0", resp_valid); else n_pass++;
        n_total++;
        load(2'd2, 1'b0, 64'h3C, d, f, lat);
        if (d !== 64'h05060708) $display("FAIL rsplit_beat1 got %h exp 05060708", d); else n_pass++;
        n_total++;
        load(2'd2, 1'b0, 64'h40, d, f, lat);
        if (d !== 64'h0) $display("FAIL rsplit_beat2 got %h exp 0", d); else n_pass++;
        n_total++;
    endtask

    initial begin
        rst_l = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        address = 64'h0; write_data = 64'h0;
        s_req_valid = 1'b0; s_req_write = 1'b0; s_req_size = 2'd0; s_req_signed = 1'b0;
        s_address = 64'h0; s_write_data = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_l = 1'b1;
        clear_mem();
        test_reset();
        test_aligned();
        test_subword();
        test_split();
        test_fault();
        test_narrow();
        test_reset_split();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
